// File: rtl/cbfp_block_norm.sv
// Block-floating-point normaliser: gathers BLK_BEATS beats into one block, finds the
// block-wide minimum redundant-sign-bit count, then replays the block shifted by it.
module cbfp_block_norm #(
    parameter int LANES       = 16,
    parameter int IN_WIDTH    = 23,
    parameter int OUT_WIDTH   = 13,
    parameter int BLK_BEATS   = 4,
    parameter int SHIFT_WIDTH = 5,
    parameter int MAX_SHIFT   = IN_WIDTH - 1,
    parameter bit JOINT_EXP   = 1'b0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 din_valid,
    input  logic [LANES-1:0][IN_WIDTH-1:0]       din_real,
    input  logic [LANES-1:0][IN_WIDTH-1:0]       din_imag,
    output logic                                 valid_out,
    output logic [LANES-1:0][OUT_WIDTH-1:0]      dout_real,
    output logic [LANES-1:0][OUT_WIDTH-1:0]      dout_imag,
    output logic [SHIFT_WIDTH-1:0]               exp_re,
    output logic [SHIFT_WIDTH-1:0]               exp_im,
    output logic                                 blk_first,
    output logic                                 blk_last
);
    localparam int CW = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;
    localparam logic [CW-1:0]          LAST    = CW'(BLK_BEATS - 1);
    localparam logic [SHIFT_WIDTH-1:0] MAXS    = SHIFT_WIDTH'(MAX_SHIFT);
    localparam logic [SHIFT_WIDTH-1:0] RSB_MAX = SHIFT_WIDTH'(IN_WIDTH - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    function automatic logic [SHIFT_WIDTH-1:0] rsb(input logic [IN_WIDTH-1:0] x);
        logic run;
        int   n;
        run = 1'b1;
        n   = 0;
        for (int b = IN_WIDTH - 2; b >= 0; b--) begin
            if (run && (x[b] == x[IN_WIDTH-1])) n++;
            else run = 1'b0;
        end
        return SHIFT_WIDTH'(n);
    endfunction

    logic [1:0][BLK_BEATS-1:0][LANES-1:0][IN_WIDTH-1:0] bank_re_q, bank_im_q;
    logic [CW-1:0]          wr_cnt_q;
    logic                   wr_bank_q;
    logic [SHIFT_WIDTH-1:0] run_min_re_q, run_min_im_q;
    logic [SHIFT_WIDTH-1:0] blk_exp_re_q, blk_exp_im_q;
    logic                   rd_start_q;

    logic [LANES-1:0][SHIFT_WIDTH-1:0] rsb_re, rsb_im;
    logic [SHIFT_WIDTH-1:0] beat_min_re, beat_min_im;
    logic [SHIFT_WIDTH-1:0] run_min_re_d, run_min_im_d;
    logic [SHIFT_WIDTH-1:0] blk_exp_re_d, blk_exp_im_d;

    for (genvar l = 0; l < LANES; l++) begin : g_rsb
        assign rsb_re[l] = rsb(din_real[l]);
        assign rsb_im[l] = rsb(din_imag[l]);
    end

    always_comb begin
        beat_min_re = RSB_MAX;
        beat_min_im = RSB_MAX;
        for (int l = 0; l < LANES; l++) begin
            if (rsb_re[l] < beat_min_re) beat_min_re = rsb_re[l];
            if (rsb_im[l] < beat_min_im) beat_min_im = rsb_im[l];
        end
        run_min_re_d = (beat_min_re < run_min_re_q) ? beat_min_re : run_min_re_q;
        run_min_im_d = (beat_min_im < run_min_im_q) ? beat_min_im : run_min_im_q;
        blk_exp_re_d = (run_min_re_d < MAXS) ? run_min_re_d : MAXS;
        blk_exp_im_d = (run_min_im_d < MAXS) ? run_min_im_d : MAXS;
        if (JOINT_EXP) begin
            if (blk_exp_im_d < blk_exp_re_d) blk_exp_re_d = blk_exp_im_d;
            else                             blk_exp_im_d = blk_exp_re_d;
        end
    end

    // Sample storage carries no reset: a discarded partial block is simply overwritten.
    always_ff @(posedge clk) begin
        if (din_valid) begin
            bank_re_q[wr_bank_q][wr_cnt_q] <= din_real;
            bank_im_q[wr_bank_q][wr_cnt_q] <= din_imag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q     <= '0;
            wr_bank_q    <= 1'b0;
            run_min_re_q <= MAXS;
            run_min_im_q <= MAXS;
            blk_exp_re_q <= '0;
            blk_exp_im_q <= '0;
            rd_start_q   <= 1'b0;
        end else begin
            rd_start_q <= 1'b0;
            if (din_valid) begin
                if (wr_cnt_q == LAST) begin
                    wr_cnt_q     <= '0;
                    wr_bank_q    <= ~wr_bank_q;
                    run_min_re_q <= MAXS;
                    run_min_im_q <= MAXS;
                    blk_exp_re_q <= blk_exp_re_d;
                    blk_exp_im_q <= blk_exp_im_d;
                    rd_start_q   <= 1'b1;
                end else begin
                    wr_cnt_q     <= wr_cnt_q + 1'b1;
                    run_min_re_q <= run_min_re_d;
                    run_min_im_q <= run_min_im_d;
                end
            end
        end
    end

    state_t                 state_q, state_d;
    logic [CW-1:0]          rd_cnt_q, rd_cnt_d;
    logic                   rd_bank_q, rd_bank_d;
    logic [SHIFT_WIDTH-1:0] rd_exp_re_q, rd_exp_re_d, rd_exp_im_q, rd_exp_im_d;
    logic [LANES-1:0][OUT_WIDTH-1:0] shift_re, shift_im;
    logic [LANES-1:0][OUT_WIDTH-1:0] dout_real_d, dout_imag_d;
    logic [SHIFT_WIDTH-1:0] exp_re_d, exp_im_d;
    logic                   valid_d, first_d, last_d, load;

    // Shift within IN_WIDTH, then keep the top OUT_WIDTH bits (floor truncation).
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign shift_re[l] = OUT_WIDTH'((bank_re_q[rd_bank_q][rd_cnt_q][l] << rd_exp_re_q)
                                        >> (IN_WIDTH - OUT_WIDTH));
        assign shift_im[l] = OUT_WIDTH'((bank_im_q[rd_bank_q][rd_cnt_q][l] << rd_exp_im_q)
                                        >> (IN_WIDTH - OUT_WIDTH));
    end

    assign load = rd_start_q && ((state_q == IDLE) || (rd_cnt_q == LAST));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rd_start_q) state_d = DRAIN;
            DRAIN:   if (rd_cnt_q == LAST) state_d = rd_start_q ? DRAIN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_cnt_d    = rd_cnt_q;
        rd_bank_d   = rd_bank_q;
        rd_exp_re_d = rd_exp_re_q;
        rd_exp_im_d = rd_exp_im_q;
        valid_d     = 1'b0;
        first_d     = 1'b0;
        last_d      = 1'b0;
        exp_re_d    = '0;
        exp_im_d    = '0;
        dout_real_d = '0;
        dout_imag_d = '0;
        if (state_q == DRAIN) begin
            valid_d     = 1'b1;
            first_d     = (rd_cnt_q == '0);
            last_d      = (rd_cnt_q == LAST);
            exp_re_d    = rd_exp_re_q;
            exp_im_d    = rd_exp_im_q;
            dout_real_d = shift_re;
            dout_imag_d = shift_im;
            rd_cnt_d    = (rd_cnt_q == LAST) ? '0 : rd_cnt_q + 1'b1;
        end
        // The bank just filled is the one the writer toggled away from.
        if (load) begin
            rd_cnt_d    = '0;
            rd_bank_d   = ~wr_bank_q;
            rd_exp_re_d = blk_exp_re_q;
            rd_exp_im_d = blk_exp_im_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_exp_re_q <= '0;
            rd_exp_im_q <= '0;
            valid_out   <= 1'b0;
            blk_first   <= 1'b0;
            blk_last    <= 1'b0;
            exp_re      <= '0;
            exp_im      <= '0;
            dout_real   <= '0;
            dout_imag   <= '0;
        end else begin
            rd_cnt_q    <= rd_cnt_d;
            rd_bank_q   <= rd_bank_d;
            rd_exp_re_q <= rd_exp_re_d;
            rd_exp_im_q <= rd_exp_im_d;
            valid_out   <= valid_d;
            blk_first   <= first_d;
            blk_last    <= last_d;
            exp_re      <= exp_re_d;
            exp_im      <= exp_im_d;
            dout_real   <= dout_real_d;
            dout_imag   <= dout_imag_d;
        end
    end
endmodule
